// File: rtl/health_supervisor.sv
// Output-gain supervisor: mutes on monitor fault, holds, re-arms the monitor, ramps back to unity.
// Latency: every output is registered, so a gain step appears one cycle after its sample_valid strobe.
// Backpressure: none; i_enable low freezes state/gain/counters. Macro HEALTH_LOCKOUT_EN adds the LOCKED state.
module health_supervisor #(
    parameter int data_width      = 16,
    parameter int ramp_step       = 256,
    parameter int holdoff_samples = 4800,
    parameter int max_faults      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_sample_valid,
    input  logic                  i_health,
    input  logic                  i_peak_detect,
    input  logic                  i_envl_detect,
    input  logic                  i_rearm,
    output logic                  o_monitor_reset,
    output logic [data_width-1:0] o_gain,
    output logic                  o_muted,
    output logic [7:0]            o_fault_count,
    output logic [1:0]            o_fault_cause,
    output logic                  o_lockout
);
    localparam int GW = data_width + 1;
    localparam int HW = (holdoff_samples > 1) ? $clog2(holdoff_samples) : 1;
    localparam logic [data_width-1:0] UNITY     = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [GW-1:0]         UNITY_X   = {1'b0, UNITY};
    localparam logic [GW-1:0]         STEP      = GW'(ramp_step);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(holdoff_samples - 1);

`ifdef HEALTH_LOCKOUT_EN
    localparam logic [7:0] FAULT_LIMIT = 8'(max_faults);
    typedef enum logic [2:0] {S_RUN, S_MUTE, S_HOLD, S_REARM, S_RAMP, S_LOCKED} state_t;
`else
    localparam int unused_max_faults = max_faults;
    typedef enum logic [2:0] {S_RUN, S_MUTE, S_HOLD, S_REARM, S_RAMP} state_t;
`endif

    state_t                r_state, w_state;
    logic [data_width-1:0] r_gain, w_gain;
    logic                  r_muted, w_muted;
    logic                  r_monitor_reset, w_monitor_reset;
    logic                  r_mr_cnt, w_mr_cnt;
    logic [7:0]            r_fault_count, w_fault_count;
    logic [1:0]            r_fault_cause, w_fault_cause;
    logic                  r_lockout, w_lockout;
    logic [HW-1:0]         r_hold_cnt, w_hold_cnt;

    logic [GW-1:0]         w_gain_ext, w_diff, w_sum;
    logic [data_width-1:0] w_gain_dec, w_gain_inc;
    logic [7:0]            w_fault_inc;
    logic                  w_mr_set, w_mr_last;

    // Extra headroom bit turns underflow into a sign bit and keeps the sum from wrapping.
    assign w_gain_ext  = {1'b0, r_gain};
    assign w_diff      = w_gain_ext - STEP;
    assign w_sum       = w_gain_ext + STEP;
    assign w_gain_dec  = w_diff[data_width] ? '0 : w_diff[data_width-1:0];
    assign w_gain_inc  = (w_sum >= UNITY_X) ? UNITY : w_sum[data_width-1:0];
    assign w_fault_inc = (r_fault_count == 8'hFF) ? r_fault_count : r_fault_count + 8'd1;
    assign w_mr_last   = r_monitor_reset && r_mr_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_gain        = r_gain;
        w_hold_cnt    = r_hold_cnt;
        w_fault_count = r_fault_count;
        w_fault_cause = r_fault_cause;
        w_mr_set      = 1'b0;

        if (i_enable) begin
            unique case (r_state)
                S_RUN: begin
                    w_gain = UNITY;
                    if (i_rearm) begin
                        w_fault_count = 8'd0;
                        w_fault_cause = 2'b00;
                    end
                    if (!i_health) begin
                        w_state       = S_MUTE;
                        w_fault_cause = {i_envl_detect, i_peak_detect};
                        w_fault_count = i_rearm ? 8'd1 : w_fault_inc;
                    end
                end
                S_MUTE: begin
                    if (r_gain == '0) begin
                        w_state    = S_HOLD;
                        w_hold_cnt = '0;
                    end else if (i_sample_valid) begin
                        w_gain = w_gain_dec;
                        if (w_gain_dec == '0) begin
                            w_state    = S_HOLD;
                            w_hold_cnt = '0;
                        end
                    end
                end
                S_HOLD: begin
                    w_gain = '0;
                    if (i_sample_valid) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            w_state    = S_REARM;
                            w_hold_cnt = '0;
                            w_mr_set   = 1'b1;
                        end else begin
                            w_hold_cnt = r_hold_cnt + HW'(1);
                        end
                    end
                end
                S_REARM: begin
                    // Leave on the pulse's last cycle, or later if enable dropped while it finished.
                    if (w_mr_last || !r_monitor_reset) begin
`ifdef HEALTH_LOCKOUT_EN
                        w_state = (r_fault_count >= FAULT_LIMIT) ? S_LOCKED : S_RAMP;
`else
                        w_state = S_RAMP;
`endif
                    end
                end
                S_RAMP: begin
                    if (!i_health) begin
                        w_state       = S_MUTE;
                        w_fault_cause = {i_envl_detect, i_peak_detect};
                        w_fault_count = w_fault_inc;
                    end else if (i_sample_valid) begin
                        w_gain = w_gain_inc;
                        if (w_gain_inc == UNITY) begin
                            w_state = S_RUN;
                        end
                    end
                end
`ifdef HEALTH_LOCKOUT_EN
                S_LOCKED: begin
                    w_gain = '0;
                    if (i_rearm) begin
                        w_state       = S_REARM;
                        w_fault_count = 8'd0;
                        w_mr_set      = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state = S_RUN;
                end
            endcase
        end

        // The monitor-reset pulse always runs to completion, even with enable low.
        w_monitor_reset = r_monitor_reset;
        w_mr_cnt        = r_mr_cnt;
        if (w_mr_set) begin
            w_monitor_reset = 1'b1;
            w_mr_cnt        = 1'b0;
        end else if (r_monitor_reset) begin
            if (r_mr_cnt) begin
                w_monitor_reset = 1'b0;
                w_mr_cnt        = 1'b0;
            end else begin
                w_mr_cnt = 1'b1;
            end
        end

        w_muted = (w_gain == '0);
`ifdef HEALTH_LOCKOUT_EN
        w_lockout = (w_state == S_LOCKED);
`else
        w_lockout = 1'b0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gain          <= UNITY;
            r_muted         <= 1'b0;
            r_monitor_reset <= 1'b1;
            r_mr_cnt        <= 1'b1;
            r_fault_count   <= 8'd0;
            r_fault_cause   <= 2'b00;
            r_lockout       <= 1'b0;
            r_hold_cnt      <= '0;
        end else begin
            r_gain          <= w_gain;
            r_muted         <= w_muted;
            r_monitor_reset <= w_monitor_reset;
            r_mr_cnt        <= w_mr_cnt;
            r_fault_count   <= w_fault_count;
            r_fault_cause   <= w_fault_cause;
            r_lockout       <= w_lockout;
            r_hold_cnt      <= w_hold_cnt;
        end
    end

    assign o_monitor_reset = r_monitor_reset;
    assign o_gain          = r_gain;
    assign o_muted         = r_muted;
    assign o_fault_count   = r_fault_count;
    assign o_fault_cause   = r_fault_cause;
    assign o_lockout       = r_lockout;

endmodule

// File: tb/tb_health_supervisor.sv
// Directed bench for health_supervisor: fault/mute/hold/rearm/ramp cycle, enable freeze, reset and rearm corners.
module tb_health_supervisor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, sample_valid, health, peak_detect, envl_detect, rearm;
    logic        monitor_reset, muted, lockout;
    logic [15:0] gain;
    logic [7:0]  fault_count;
    logic [1:0]  fault_cause;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_fc;

    health_supervisor #(
        .data_width     (16),
        .ramp_step      ('h0800),
        .holdoff_samples(8),
        .max_faults     (2)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_sample_valid (sample_valid),
        .i_health       (health),
        .i_peak_detect  (peak_detect),
        .i_envl_detect  (envl_detect),
        .i_rearm        (rearm),
        .o_monitor_reset(monitor_reset),
        .o_gain         (gain),
        .o_muted        (muted),
        .o_fault_count  (fault_count),
        .o_fault_cause  (fault_cause),
        .o_lockout      (lockout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sample period: strobe for one cycle, then three idle cycles.
    task automatic strobes(input int n);
        repeat (n) begin
            sample_valid = 1'b1;
            @(negedge clk);
            sample_valid = 1'b0;
            cyc(3);
        end
    endtask

    // Final HOLD strobe, then the two-cycle monitor-reset pulse cycle by cycle.
    task automatic last_hold_strobe();
        check("mr_low_before_rearm", monitor_reset, 0);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("mr_pulse_cycle1", monitor_reset, 1);
        cyc(1);
        check("mr_pulse_cycle2", monitor_reset, 1);
        cyc(1);
        check("mr_pulse_ended", monitor_reset, 0);
        check("gain_zero_after_rearm", gain, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; health = 1'b1;
        peak_detect = 1'b0; envl_detect = 1'b0; rearm = 1'b0;
        cyc(2);
        check("rst_gain", gain, 16'h8000);
        check("rst_muted", muted, 0);
        check("rst_mr", monitor_reset, 1);
        check("rst_fc", fault_count, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_lockout", lockout, 0);
        reset = 1'b0;
        cyc(1);
        check("mr_drops_after_rst", monitor_reset, 0);
        check("run_gain", gain, 16'h8000);

        // First fault: peak cause.
        health = 1'b0; peak_detect = 1'b1;
        cyc(1);
        health = 1'b1; peak_detect = 1'b0;
        check("f1_count", fault_count, 1);
        check("f1_cause", fault_cause, 2'b01);
        check("f1_gain_no_jump", gain, 16'h8000);
        strobes(4);
        check("mute_gain_6000", gain, 16'h6000);

        // Enable low for 20 cycles with strobes and a fault flag present.
        enable = 1'b0; health = 1'b0;
        strobes(5);
        check("freeze_gain", gain, 16'h6000);
        check("freeze_fc", fault_count, 1);
        enable = 1'b1; health = 1'b1;
        strobes(11);
        check("mute_gain_0800", gain, 16'h0800);
        check("mute_not_muted", muted, 0);
        strobes(1);
        check("mute_gain_zero", gain, 16'h0000);
        check("mute_muted", muted, 1);

        // HOLD ignores health.
        health = 1'b0;
        strobes(7);
        check("hold_gain", gain, 16'h0000);
        check("hold_fc", fault_count, 1);
        health = 1'b1;
        last_hold_strobe();

        strobes(8);
        check("ramp_gain_4000", gain, 16'h4000);
        check("ramp_unmuted", muted, 0);

        // Second fault mid-ramp: envelope cause, mute from current gain.
        health = 1'b0; envl_detect = 1'b1;
        cyc(1);
        health = 1'b1; envl_detect = 1'b0;
        check("f2_count", fault_count, 2);
        check("f2_cause", fault_cause, 2'b10);
        check("f2_gain_no_jump", gain, 16'h4000);
        strobes(7);
        check("f2_gain_0800", gain, 16'h0800);
        strobes(1);
        check("f2_gain_zero", gain, 16'h0000);
        strobes(7);
        last_hold_strobe();

`ifdef HEALTH_LOCKOUT_EN
        check("lock_lockout", lockout, 1);
        check("lock_gain", gain, 16'h0000);
        check("lock_fc", fault_count, 2);
        strobes(2);
        check("lock_stays", lockout, 1);
        check("lock_gain_stays", gain, 16'h0000);
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        check("unlock_fc", fault_count, 0);
        check("unlock_lockout", lockout, 0);
        check("unlock_mr1", monitor_reset, 1);
        cyc(1);
        check("unlock_mr2", monitor_reset, 1);
        cyc(1);
        check("unlock_mr_end", monitor_reset, 0);
        exp_fc = 8'd0;
`else
        check("no_lockout", lockout, 0);
        exp_fc = 8'd2;
`endif

        strobes(8);
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        check("rearm_ignored_in_ramp", fault_count, exp_fc);
        strobes(7);
        check("ramp_gain_7800", gain, 16'h7800);
        strobes(1);
        check("ramp_unity", gain, 16'h8000);
        check("ramp_unity_unmuted", muted, 0);

        // Rearm and fault in the same RUN cycle: clear then count.
        rearm = 1'b1; health = 1'b0; peak_detect = 1'b1; envl_detect = 1'b1;
        cyc(1);
        rearm = 1'b0; health = 1'b1; peak_detect = 1'b0; envl_detect = 1'b0;
        check("coinc_fc", fault_count, 1);
        check("coinc_cause", fault_cause, 2'b11);
        strobes(16);
        check("coinc_gain_zero", gain, 16'h0000);
        strobes(3);

        // Reset in the middle of HOLD.
        reset = 1'b1; enable = 1'b0;
        cyc(1);
        reset = 1'b0; enable = 1'b1;
        check("hold_rst_gain", gain, 16'h8000);
        check("hold_rst_fc", fault_count, 0);
        check("hold_rst_cause", fault_cause, 0);
        check("hold_rst_muted", muted, 0);
        check("hold_rst_mr", monitor_reset, 1);
        cyc(1);
        health = 1'b0; peak_detect = 1'b1;
        cyc(1);
        health = 1'b1; peak_detect = 1'b0;
        check("post_rst_fault_fc", fault_count, 1);
        check("post_rst_fault_cause", fault_cause, 2'b01);
        rearm = 1'b1;
        cyc(1);
        rearm = 1'b0;
        check("rearm_ignored_in_mute", fault_count, 1);
        strobes(1);
        check("post_rst_mute_step", gain, 16'h7800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
